// File: rtl/lbdr_pkg.sv
// Shared flit encodings, FSM states and port/deroute indices for the LBDR routing unit.
package lbdr_pkg;

    localparam logic [2:0] FlitHeader = 3'b001;
    localparam logic [2:0] FlitBody   = 3'b010;
    localparam logic [2:0] FlitTail   = 3'b100;

    typedef enum logic [1:0] {StIdle, StRouted, StForward} state_e;

    // Port indices match the bit order of the Cx configuration word.
    localparam int unsigned PortN    = 0;
    localparam int unsigned PortE    = 1;
    localparam int unsigned PortW    = 2;
    localparam int unsigned PortS    = 3;
    localparam int unsigned PortL    = 4;
    localparam int unsigned NumPorts = 5;

    localparam logic [1:0] DrN = 2'b00;
    localparam logic [1:0] DrE = 2'b01;
    localparam logic [1:0] DrW = 2'b10;
    localparam logic [1:0] DrS = 2'b11;

endpackage

// File: rtl/lbdr_route_logic.sv
// Combinational LBDR comparators, minimal port equations and optional deroute
// (deroute built only when LBDR_DEROUTE_EN is defined).
module lbdr_route_logic
    import lbdr_pkg::*;
#(
    parameter int unsigned X_W = 2,
    parameter int unsigned Y_W = 2
) (
    input  logic [X_W+Y_W-1:0]  cur_addr_i,
    input  logic [X_W+Y_W-1:0]  dst_addr_i,
    input  logic [7:0]          rxy_i,
    input  logic [3:0]          cx_i,
`ifdef LBDR_DEROUTE_EN
    input  logic [7:0]          dr_i,
`endif
    output logic [NumPorts-1:0] route_o
);

    logic [X_W-1:0] x_cur, x_dst;
    logic [Y_W-1:0] y_cur, y_dst;
    logic n1, e1, w1, s1;
    logic rsw, rse, rws, rwn, res, ren, rnw, rne;
    logic [NumPorts-1:0] min_route;

    assign x_cur = cur_addr_i[X_W-1:0];
    assign y_cur = cur_addr_i[X_W+:Y_W];
    assign x_dst = dst_addr_i[X_W-1:0];
    assign y_dst = dst_addr_i[X_W+:Y_W];

    assign n1 = y_dst < y_cur;
    assign s1 = y_cur < y_dst;
    assign e1 = x_cur < x_dst;
    assign w1 = x_dst < x_cur;

    assign {rsw, rse, rws, rwn, res, ren, rnw, rne} = rxy_i;

    always_comb begin
        min_route        = '0;
        min_route[PortN] = ((n1 & ~e1 & ~w1) | (n1 & e1 & rne) | (n1 & w1 & rnw)) & cx_i[PortN];
        min_route[PortE] = ((e1 & ~n1 & ~s1) | (e1 & n1 & ren) | (e1 & s1 & res)) & cx_i[PortE];
        min_route[PortW] = ((w1 & ~n1 & ~s1) | (w1 & n1 & rwn) | (w1 & s1 & rws)) & cx_i[PortW];
        min_route[PortS] = ((s1 & ~e1 & ~w1) | (s1 & e1 & rse) | (s1 & w1 & rsw)) & cx_i[PortS];
        min_route[PortL] = ~n1 & ~e1 & ~w1 & ~s1;
    end

`ifdef LBDR_DEROUTE_EN
    logic [3:0] dir;
    logic [1:0] dr_code;
    logic [3:0] dr_vec;

    assign dir = {s1, w1, e1, n1};

    // Deroute only for a pure single-direction destination whose minimal port is cut.
    always_comb begin
        case (dir)
            4'b0001: dr_code = dr_i[1:0];
            4'b0010: dr_code = dr_i[3:2];
            4'b0100: dr_code = dr_i[5:4];
            4'b1000: dr_code = dr_i[7:6];
            default: dr_code = DrN;
        endcase
        dr_vec = '0;
        if (min_route == '0 && $onehot(dir)) begin
            unique case (dr_code)
                DrN: dr_vec[PortN] = cx_i[PortN];
                DrE: dr_vec[PortE] = cx_i[PortE];
                DrW: dr_vec[PortW] = cx_i[PortW];
                DrS: dr_vec[PortS] = cx_i[PortS];
            endcase
        end
        route_o = min_route | {1'b0, dr_vec};
    end
`else
    assign route_o = min_route;
`endif

endmodule

// File: rtl/lbdr_param.sv
// Packet-aware LBDR routing unit: routes a HEADER once and holds the port until TAIL accept.
// Optional deroute stage enabled by defining LBDR_DEROUTE_EN.
module lbdr_param
    import lbdr_pkg::*;
#(
    parameter int unsigned X_W = 2,
    parameter int unsigned Y_W = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flit_valid,
    input  logic               flit_accept,
    input  logic [2:0]         flit_id,
    input  logic [X_W+Y_W-1:0] dst_addr,
    input  logic [7:0]         Rxy_rst,
    input  logic [3:0]         Cx_rst,
    input  logic [7:0]         dr_rst,
    input  logic [X_W+Y_W-1:0] cur_addr_rst,
    output logic               Nport,
    output logic               Eport,
    output logic               Wport,
    output logic               Sport,
    output logic               Lport,
    output logic               route_valid,
    output logic               route_err
);

    state_e                state_q, state_d;
    logic [NumPorts-1:0]   route_q, route_d;
    logic                  valid_q, valid_d;
    logic                  err_q, err_d;
    logic [7:0]            rxy_q;
    logic [3:0]            cx_q;
    logic [X_W+Y_W-1:0]    cur_q;
    logic [NumPorts-1:0]   new_route;
    logic                  is_hdr, is_body_tail;

`ifdef LBDR_DEROUTE_EN
    logic [7:0] dr_q;

    always_ff @(posedge clk) begin
        if (rst) dr_q <= dr_rst;
    end
`else
    logic unused_dr;
    assign unused_dr = ^dr_rst;
`endif

    // Configuration is only ever loaded while reset is held.
    always_ff @(posedge clk) begin
        if (rst) begin
            rxy_q <= Rxy_rst;
            cx_q  <= Cx_rst;
            cur_q <= cur_addr_rst;
        end
    end

    lbdr_route_logic #(
        .X_W (X_W),
        .Y_W (Y_W)
    ) u_route_logic (
        .cur_addr_i (cur_q),
        .dst_addr_i (dst_addr),
        .rxy_i      (rxy_q),
        .cx_i       (cx_q),
`ifdef LBDR_DEROUTE_EN
        .dr_i       (dr_q),
`endif
        .route_o    (new_route)
    );

    assign is_hdr       = flit_id == FlitHeader;
    assign is_body_tail = (flit_id == FlitBody) || (flit_id == FlitTail);

    always_comb begin
        state_d = state_q;
        route_d = route_q;
        valid_d = valid_q;
        err_d   = 1'b0;
        if (flit_valid) begin
            unique case (state_q)
                StIdle: begin
                    if (is_hdr) begin
                        if (|new_route) begin
                            route_d = new_route;
                            valid_d = 1'b1;
                            state_d = flit_accept ? StForward : StRouted;
                        end else begin
                            err_d = 1'b1;
                        end
                    end else if (is_body_tail) begin
                        err_d = 1'b1;
                    end
                end
                StRouted: begin
                    if (is_hdr && flit_accept) begin
                        state_d = StForward;
                    end else if (is_body_tail) begin
                        err_d = 1'b1;
                    end
                end
                StForward: begin
                    if (flit_accept && flit_id == FlitTail) begin
                        route_d = '0;
                        valid_d = 1'b0;
                        state_d = StIdle;
                    end else if (is_hdr) begin
                        err_d = 1'b1;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            route_q <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            route_q <= route_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    assign Nport       = route_q[PortN];
    assign Eport       = route_q[PortE];
    assign Wport       = route_q[PortW];
    assign Sport       = route_q[PortS];
    assign Lport       = route_q[PortL];
    assign route_valid = valid_q;
    assign route_err   = err_q;

endmodule

// File: tb/tb_lbdr_param.sv
// Self-checking bench for lbdr_param: directed scenarios plus randomized traffic
// checked against a packet-level reference model.
module tb_lbdr_param;
    import lbdr_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, flit_valid, flit_accept;
    logic [2:0] flit_id;
    logic [3:0] dst_addr, cur_rst, cx_rst;
    logic [7:0] rxy_rst, dr_rst;
    logic [5:0] dst_b, cur_b;
    logic       n_p, e_p, w_p, s_p, l_p, route_valid, route_err;
    logic       bn, be, bw, bs, bl, b_valid, b_err;

    int n_chk = 0;
    int n_fail = 0;

    // Reference model state
    logic [3:0] m_cur, m_cx;
    logic [7:0] m_rxy, m_dr;
    logic [4:0] m_route;
    logic       m_held, m_hdr_taken, m_err;

    lbdr_param #(.X_W(2), .Y_W(2)) dut (
        .clk(clk), .rst(rst), .flit_valid(flit_valid), .flit_accept(flit_accept),
        .flit_id(flit_id), .dst_addr(dst_addr), .Rxy_rst(rxy_rst), .Cx_rst(cx_rst),
        .dr_rst(dr_rst), .cur_addr_rst(cur_rst), .Nport(n_p), .Eport(e_p), .Wport(w_p),
        .Sport(s_p), .Lport(l_p), .route_valid(route_valid), .route_err(route_err)
    );

    lbdr_param #(.X_W(3), .Y_W(3)) dut_b (
        .clk(clk), .rst(rst), .flit_valid(flit_valid), .flit_accept(flit_accept),
        .flit_id(flit_id), .dst_addr(dst_b), .Rxy_rst(rxy_rst), .Cx_rst(cx_rst),
        .dr_rst(dr_rst), .cur_addr_rst(cur_b), .Nport(bn), .Eport(be), .Wport(bw),
        .Sport(bs), .Lport(bl), .route_valid(b_valid), .route_err(b_err)
    );

    function automatic logic [6:0] obs_a();
        return {route_err, route_valid, l_p, s_p, w_p, e_p, n_p};
    endfunction

    function automatic logic [6:0] obs_b();
        return {b_err, b_valid, bl, bs, bw, be, bn};
    endfunction

    // Route by destination quadrant; bit order {L,S,W,E,N}.
    function automatic logic [4:0] model_route(int cx, int cy, int dx, int dy,
                                               logic [7:0] r, logic [3:0] c, logic [7:0] d);
        bit north = dy < cy, south = dy > cy, east = dx > cx, west = dx < cx;
        logic [4:0] v = '0;
        int di, p;
        if (!north && !south && !east && !west) return 5'b10000;
        if (north && east) begin v[0] = r[0] & c[0]; v[1] = r[2] & c[1]; end
        else if (north && west) begin v[0] = r[1] & c[0]; v[2] = r[4] & c[2]; end
        else if (south && east) begin v[3] = r[6] & c[3]; v[1] = r[3] & c[1]; end
        else if (south && west) begin v[3] = r[7] & c[3]; v[2] = r[5] & c[2]; end
        else if (north) v[0] = c[0];
        else if (east)  v[1] = c[1];
        else if (west)  v[2] = c[2];
        else            v[3] = c[3];
`ifdef LBDR_DEROUTE_EN
        if (v == 5'b0 && (int'(north) + int'(south) + int'(east) + int'(west)) == 1) begin
            di = north ? 0 : east ? 1 : west ? 2 : 3;
            p = int'(d[2*di +: 2]);
            v[p] = c[p];
        end
`endif
        return v;
    endfunction

    task automatic model_clock();
        logic [4:0] nv;
        bit hdr = flit_id == FlitHeader;
        bit bt  = (flit_id == FlitBody) || (flit_id == FlitTail);
        if (rst) begin
            m_cur = cur_rst; m_cx = cx_rst; m_rxy = rxy_rst; m_dr = dr_rst;
            m_held = 0; m_hdr_taken = 0; m_route = '0; m_err = 0;
        end else begin
            m_err = 0;
            if (flit_valid) begin
                if (!m_held) begin
                    if (hdr) begin
                        nv = model_route(int'(m_cur[1:0]), int'(m_cur[3:2]), int'(dst_addr[1:0]),
                                         int'(dst_addr[3:2]), m_rxy, m_cx, m_dr);
                        if (nv != 5'b0) begin
                            m_route = nv; m_held = 1; m_hdr_taken = flit_accept;
                        end else m_err = 1;
                    end else if (bt) m_err = 1;
                end else if (!m_hdr_taken) begin
                    if (hdr && flit_accept) m_hdr_taken = 1;
                    else if (bt) m_err = 1;
                end else begin
                    if (flit_id == FlitTail && flit_accept) begin
                        m_held = 0; m_hdr_taken = 0; m_route = '0;
                    end else if (hdr) m_err = 1;
                end
            end
        end
    endtask

    task automatic tick();
        model_clock();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset(logic [3:0] cur, logic [3:0] cx, logic [7:0] rxy, logic [7:0] dr);
        cur_rst = cur; cx_rst = cx; rxy_rst = rxy; dr_rst = dr;
        flit_valid = 0; flit_accept = 0; rst = 1;
        tick();
        rst = 0;
    endtask

    task automatic drive(logic v, logic a, logic [2:0] id, logic [3:0] dst);
        flit_valid = v; flit_accept = a; flit_id = id; dst_addr = dst;
    endtask

    task automatic test_reset();
        logic [6:0] exp;
        apply_reset(4'd5, 4'hF, 8'h3C, 8'h01);
        n_chk++; exp = 7'b0;
        if (obs_a() !== exp) begin n_fail++; $display("FAIL reset_outputs: got %b want %b", obs_a(), exp); end
        drive(1, 0, FlitHeader, 4'd5); tick();
        n_chk++; exp = 7'b0110000;
        if (obs_a() !== exp) begin n_fail++; $display("FAIL local_route: got %b want %b", obs_a(), exp); end
        drive(1, 1, FlitHeader, 4'd5); tick();
        n_chk++;
        if (obs_a() !== exp) begin n_fail++; $display("FAIL local_accept: got %b want %b", obs_a(), exp); end
        drive(1, 1, FlitTail, 4'd0); tick();
        n_chk++; exp = 7'b0;
        if (obs_a() !== exp) begin n_fail++; $display("FAIL local_tail: got %b want %b", obs_a(), exp); end
    endtask

    task automatic test_packet();
        logic [6:0] exp = 7'b0100010;
        apply_reset(4'd5, 4'hF, 8'h3C, 8'h01);
        drive(1, 1, FlitHeader, 4'hF); tick();
        n_chk++;
        if (obs_a() !== exp) begin n_fail++; $display("FAIL pkt_header: got %b want %b", obs_a(), exp); end
        drive(1, 1, FlitBody, 4'd0); tick();
        n_chk++;
        if (obs_a() !== exp) begin n_fail++; $display("FAIL pkt_body: got %b want %b", obs_a(), exp); end
        drive(1, 0, FlitTail, 4'd0); tick();
        n_chk++;
        if (obs_a() !== exp) begin n_fail++; $display("FAIL pkt_tail_wait: got %b want %b", obs_a(), exp); end
        drive(1, 1, FlitTail, 4'd0); tick();
        n_chk++; exp = 7'b0;
        if (obs_a() !== exp) begin n_fail++; $display("FAIL pkt_tail_clear: got %b want %b", obs_a(), exp); end
    endtask

    task automatic test_hold();
        logic [6:0] exp = 7'b0100010;
        apply_reset(4'd5, 4'hF, 8'h3C, 8'h01);
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, FlitHeader, (i == 0) ? 4'hF : 4'd0);
            tick();
            n_chk++;
            if (obs_a() !== exp) begin
                n_fail++; $display("FAIL hold_cycle%0d: got %b want %b", i, obs_a(), exp);
            end
        end
        drive(1, 1, FlitHeader, 4'd0); tick();
        drive(1, 1, FlitBody, 4'd0); tick();
        n_chk++;
        if (obs_a() !== exp) begin n_fail++; $display("FAIL hold_forward_body: got %b want %b", obs_a(), exp); end
        drive(1, 1, FlitTail, 4'd0); tick();
        n_chk++; exp = 7'b0;
        if (obs_a() !== exp) begin n_fail++; $display("FAIL hold_tail: got %b want %b", obs_a(), exp); end
    endtask

    task automatic test_deroute();
        logic [6:0] exp;
        apply_reset(4'd5, 4'b1110, 8'h3C, 8'h01);
        drive(1, 0, FlitHeader, 4'd1); tick();
`ifdef LBDR_DEROUTE_EN
        exp = 7'b0100010;
`else
        exp = 7'b1000000;
`endif
        n_chk++;
        if (obs_a() !== exp) begin n_fail++; $display("FAIL deroute_hdr: got %b want %b", obs_a(), exp); end
        drive(0, 0, FlitBody, 4'd0); tick();
`ifdef LBDR_DEROUTE_EN
        exp = 7'b0100010;
`else
        exp = 7'b0;
`endif
        n_chk++;
        if (obs_a() !== exp) begin n_fail++; $display("FAIL deroute_next: got %b want %b", obs_a(), exp); end
    endtask

    task automatic test_fwd_err();
        logic [6:0] exp;
        apply_reset(4'd5, 4'hF, 8'h3C, 8'h01);
        drive(1, 1, FlitHeader, 4'hF); tick();
        drive(1, 1, FlitHeader, 4'd0); tick();
        n_chk++; exp = 7'b1100010;
        if (obs_a() !== exp) begin n_fail++; $display("FAIL fwd_hdr_err: got %b want %b", obs_a(), exp); end
        drive(0, 0, FlitBody, 4'd0); tick();
        n_chk++; exp = 7'b0100010;
        if (obs_a() !== exp) begin n_fail++; $display("FAIL fwd_err_pulse: got %b want %b", obs_a(), exp); end
        rst = 1; tick(); rst = 0;
        n_chk++; exp = 7'b0;
        if (obs_a() !== exp) begin n_fail++; $display("FAIL mid_pkt_reset: got %b want %b", obs_a(), exp); end
        drive(1, 0, FlitBody, 4'd0); tick();
        n_chk++; exp = 7'b1000000;
        if (obs_a() !== exp) begin n_fail++; $display("FAIL idle_body_err: got %b want %b", obs_a(), exp); end
    endtask

    task automatic test_back_to_back();
        logic [6:0] exp;
        apply_reset(4'd5, 4'hF, 8'h3C, 8'h01);
        drive(1, 1, FlitHeader, 4'hF); tick();
        drive(1, 1, FlitTail, 4'd0); tick();
        drive(1, 1, FlitHeader, 4'd0); tick();
        n_chk++; exp = 7'b0100100;
        if (obs_a() !== exp) begin n_fail++; $display("FAIL b2b_second: got %b want %b", obs_a(), exp); end
    endtask

    task automatic test_param_width();
        logic [6:0] exp = 7'b0101000;
        cur_b = {3'd4, 3'd4};
        dst_b = {3'd7, 3'd0};
        apply_reset(4'd5, 4'hF, 8'h80, 8'h01);
        drive(1, 0, FlitHeader, 4'd5); tick();
        n_chk++;
        if (obs_b() !== exp) begin n_fail++; $display("FAIL wide_sw_route: got %b want %b", obs_b(), exp); end
    endtask

    task automatic test_random();
        logic [6:0] exp;
        int sel;
        apply_reset(4'($urandom), 4'hF, 8'($urandom), 8'($urandom));
        for (int i = 0; i < 600; i++) begin
            rst = ($urandom_range(0, 63) == 0);
            if (rst) begin
                cur_rst = 4'($urandom);
                cx_rst = ($urandom_range(0, 1) != 0) ? 4'hF : 4'($urandom);
                rxy_rst = 8'($urandom);
                dr_rst = 8'($urandom);
            end
            sel = $urandom_range(0, 2);
            drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                  (sel == 0) ? FlitHeader : (sel == 1) ? FlitBody : FlitTail, 4'($urandom));
            tick();
            n_chk++; exp = {m_err, m_held, m_route};
            if (obs_a() !== exp) begin
                n_fail++; $display("FAIL random_cycle%0d: got %b want %b", i, obs_a(), exp);
            end
        end
        rst = 0;
    endtask

    initial begin
        rst = 1; flit_valid = 0; flit_accept = 0; flit_id = FlitBody; dst_addr = '0;
        cur_rst = 4'd5; cx_rst = 4'hF; rxy_rst = 8'h3C; dr_rst = 8'h01;
        cur_b = '0; dst_b = '0;
        test_reset();
        test_packet();
        test_hold();
        test_deroute();
        test_fwd_err();
        test_back_to_back();
        test_param_width();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
